audio_sample_streamer: RTL
==========================

Name: audio_sample_streamer

Overview:
- Avalon-MM read master that plays back stereo PCM samples held in the 32-bit on-chip sample memory (32000 words, single port, 1-cycle read latency, no waitrequest).
- Walks a programmable word range, unpacks each word into a left/right 16-bit pair and presents it on a valid/ready stream toward the audio codec output FIFO.
- A small prefetch FIFO hides the memory latency; supports one-shot and loop playback, plus abort.

Parameters:
- ADDR_W, 15, memory word-address width.
- MEM_WORDS, 32000, number of valid memory words; legal addresses are 0..MEM_WORDS-1.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begin playback (ignored while busy).
- stop  in  1  one-cycle pulse; abort playback.
- loop_en  in  1  sampled at start; 1 wraps from end_addr back to start_addr.
- start_addr  in  ADDR_W  first word address; sampled at start.
- end_addr  in  ADDR_W  last word address, inclusive; sampled at start.
- busy  out  1  high from an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a one-shot playback has fully drained.
- err  out  1  one-cycle pulse when a start is rejected.
- m_address  out  ADDR_W  memory word address.
- m_chipselect  out  1  read request; 1 = read this cycle.
- m_write  out  1  tied 0.
- m_byteenable  out  4  tied 4'hF.
- m_clken  out  1  tied 1.
- m_readdata  in  32  memory data, valid exactly 1 cycle after m_chipselect.
- out_left  out  16  word bits [31:16].
- out_right  out  16  word bits [15:0].
- out_valid  out  1  sample pair available.
- out_ready  in  1  consumer accepts the pair when out_valid & out_ready.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE; FIFO empty; the in-flight flag is cleared. All outputs are 0: busy, done, err, m_chipselect, m_address, out_valid, out_left, out_right.
- States and transitions:
  - IDLE: on start, check the range.
    - Legal (start_addr <= end_addr and end_addr < MEM_WORDS): latch start_addr, end_addr and loop_en; set the current address to start_addr; go to FETCH; busy=1 from the next cycle.
    - Illegal: err=1 for one cycle; stay IDLE.
  - FETCH: issue reads (rules below).
    - Read of end_addr issued with loop_en=1: the next address is the latched start_addr; stay in FETCH.
    - Read of end_addr issued with loop_en=0: go to DRAIN.
  - DRAIN: no new reads. Once the in-flight read has returned and the FIFO is empty, pulse done for one cycle, go to IDLE, busy=0.
- Read issue rule:
  - m_chipselect=1 in a FETCH cycle only when (FIFO occupancy + in-flight count + 1) <= FIFO_DEPTH.
  - At most one read is outstanding per cycle; back-to-back reads are allowed.
  - The address increments by 1 per issued read.
  - Throughput is 1 word/clk when out_ready is held high.
- Return path: m_readdata is written into the FIFO on the cycle after the request. It can never overflow, by the issue rule.
- Output side: out_valid = FIFO not empty; out_left/out_right come from the FIFO head (first-word-fall-through).
  - Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.
  - out_left/out_right hold their value while out_valid=1 and out_ready=0.
- stop (any non-IDLE state): next cycle state=IDLE, busy=0, FIFO flushed, out_valid=0, m_chipselect=0, done not pulsed.
  - A read that returns the cycle after stop is discarded.
  - stop and start in the same cycle: stop wins. A start in IDLE with stop high is ignored.
- start while busy: ignored, no err.
- start_addr == end_addr: a single word; with loop_en=1 that word repeats indefinitely.
- Address wrap past end_addr never exceeds MEM_WORDS-1.

Test Plan:
- Mem[10..13] = 32'h0001_FFFF, 32'h0002_FFFE, 32'h0003_FFFD, 32'h0004_FFFC; start 10..13, loop_en=0, out_ready=1 -> pairs (0001,FFFF)..(0004,FFFC) on 4 consecutive cycles; done pulse once; busy falls with done.
- Same range, out_ready toggling 1/0 -> identical 4-pair sequence, no loss or duplication; at most FIFO_DEPTH words fetched ahead; outputs stable while stalled.
- start 5..6, loop_en=1, out_ready=1 for 10 accepts -> words 5,6,5,6,… alternate; done never pulses.
- Stop issued mid-loop while a read is in flight -> out_valid=0 next cycle; FIFO empty; no stale pair after restarting on 20..20; done absent for the aborted run.
- start_addr=100, end_addr=99 -> err one cycle, busy stays 0, no m_chipselect; start with end_addr=32000 -> err.
- Assert reset_n=0 mid-FETCH with out_valid=1 -> all outputs 0 next cycle; a new start then plays normally.

Source files
------------

// File: rtl/audio_sample_streamer.sv
// Avalon-MM read master that streams stereo PCM words from sample memory.
// Ports: start/stop/loop_en/start_addr/end_addr control; busy/done/err
// status; m_* memory read master; out_left/out_right/out_valid/out_ready
// stream toward the codec FIFO.
module audio_sample_streamer #(
  parameter int ADDR_W     = 15,
  parameter int MEM_WORDS  = 32000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [31:0]       m_readdata,
  output logic [15:0]       out_left,
  output logic [15:0]       out_right,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] beg_q, beg_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              loop_q, loop_d;
  logic              infl_q, infl_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];

  logic legal;
  logic room;
  logic issue;
  logic push;
  logic pop;
  logic empty;

  assign empty = (cnt_q == '0);
  assign push  = infl_q;
  assign pop   = !empty && out_ready;
  assign legal = (start_addr <= end_addr) &&
                 ({1'b0, end_addr} < LIM);
  // Reserve a slot for every read in flight so returns never overflow.
  assign room  = (cnt_q + CW'(infl_q)) < DEPTH_C;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beg_d   = beg_q;
    end_d   = end_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    issue   = 1'b0;
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    mem_d   = mem_q;
    if (push) begin
      mem_d[wptr_q] = m_readdata;
    end
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (legal) begin
            state_d = S_FETCH;
            addr_d  = start_addr;
            beg_d   = start_addr;
            end_d   = end_addr;
            loop_d  = loop_en;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (room) begin
          issue = 1'b1;
          if (addr_q == end_q) begin
            if (loop_q) begin
              addr_d = beg_q;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!infl_q && empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    infl_d = issue;
    // Abort: flush everything and drop the read that returns next cycle.
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      issue   = 1'b0;
      infl_d  = 1'b0;
      done_d  = 1'b0;
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beg_q   <= '0;
      end_q   <= '0;
      loop_q  <= 1'b0;
      infl_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beg_q   <= beg_d;
      end_q   <= end_d;
      loop_q  <= loop_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign m_address    = addr_q;
  assign m_chipselect = issue;
  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;
  assign out_valid    = !empty;
  // Gate data so the stream reads zero whenever nothing is queued.
  assign out_left     = empty ? 16'h0 : mem_q[rptr_q][31:16];
  assign out_right    = empty ? 16'h0 : mem_q[rptr_q][15:0];

endmodule
